// File: rtl/red_accum_seq.sv
// red_accum_seq: sequences the shared nibble-reduction unit over a burst of operand pairs
// and accumulates each 16-bit reduction result into a running signed total.
//
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   start, len         begin a burst of len pairs (sampled only when idle)
//   abort              cancel the burst in flight, discarding the partial total
//   in_valid/in_ready  operand pair handshake; in_rs/in_rt carry the pair
//   red_rs/red_rt      registered operands driven to the reduction unit
//   red_rd             reduction unit result, combinational from red_rs/red_rt
//   busy               burst in progress
//   done               one-cycle pulse, result valid and final
//   result             accumulated total, held until the next burst completes
//   sat                (RED_ACC_SAT_EN only) a clamp occurred during the burst
//
// Build option: define RED_ACC_SAT_EN for saturating accumulation and the sat output;
// otherwise the accumulator wraps modulo 2^ACC_W.
module red_accum_seq #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_rs,
    input  logic [15:0]      in_rt,
    output logic [15:0]      red_rs,
    output logic [15:0]      red_rt,
    input  logic [15:0]      red_rd,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result
`ifdef RED_ACC_SAT_EN
    ,
    output logic             sat
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             stage_vld_q, stage_vld_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic [15:0]      rs_q, rs_d, rt_q, rt_d;
    logic [ACC_W-1:0] acc_sum;
    logic             clamp;

`ifdef RED_ACC_SAT_EN
    logic             sat_q, sat_d;
    logic [ACC_W:0]   wide_sum;

    // Sign-extend both operands by one bit; overflow shows as the top two bits differing.
    always_comb begin
        wide_sum = {acc_q[ACC_W-1], acc_q} + {red_rd[ACC_W-1], red_rd[ACC_W-1:0]};
        clamp    = wide_sum[ACC_W] != wide_sum[ACC_W-1];
        if (!clamp) begin
            acc_sum = wide_sum[ACC_W-1:0];
        end else if (wide_sum[ACC_W]) begin
            acc_sum = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_sum = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign sat = sat_q;
`else
    assign acc_sum = acc_q + red_rd[ACC_W-1:0];
    assign clamp   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stage_vld_d = 1'b0;
        acc_d       = acc_q;
        result_d    = result_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        in_ready    = 1'b0;
        done        = 1'b0;
        busy        = (state_q != StIdle);
`ifdef RED_ACC_SAT_EN
        sat_d       = sat_q;
`endif

        // The pair loaded last cycle is at red_rd now; fold it in.
        if (stage_vld_q) begin
            acc_d = acc_sum;
`ifdef RED_ACC_SAT_EN
            sat_d = sat_q | clamp;
`endif
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d = len;
                    acc_d = '0;
`ifdef RED_ACC_SAT_EN
                    sat_d = 1'b0;
`endif
                    if (len == '0) begin
                        state_d  = StDone;
                        result_d = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                in_ready = (rem_q != '0);
                if (in_valid && in_ready) begin
                    rs_d        = in_rs;
                    rt_d        = in_rt;
                    stage_vld_d = 1'b1;
                    rem_d       = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Last pair is in the stage; its sum is the final total.
                state_d  = StDone;
                result_d = acc_sum;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything in flight and leaves result untouched.
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            stage_vld_d = 1'b0;
            rem_d       = '0;
            in_ready    = 1'b0;
            done        = 1'b0;
            result_d    = result_q;
            rs_d        = rs_q;
            rt_d        = rt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            stage_vld_q <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
`ifdef RED_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stage_vld_q <= stage_vld_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
`ifdef RED_ACC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign red_rs = rs_q;
    assign red_rt = rt_q;
    assign result = result_q;

    // clamp is only consumed by the saturating build.
    logic unused_clamp;
    assign unused_clamp = clamp;

endmodule

// File: tb/tb_red_accum_seq.sv
// Self-checking bench for red_accum_seq. Two instances share stimulus: the default
// 16-bit accumulator and an 8-bit one that exercises wrap (or saturation with
// RED_ACC_SAT_EN). Each instance drives its own nibble-reduction unit model.
module tb_red_accum_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_rs, in_rt;

    logic        in_ready16, busy16, done16;
    logic [15:0] red_rs16, red_rt16, red_rd16, result16;
    logic        in_ready8, busy8, done8;
    logic [15:0] red_rs8, red_rt8, red_rd8;
    logic [7:0]  result8;
`ifdef RED_ACC_SAT_EN
    logic        sat16, sat8;
`endif

    int n_pass   = 0;
    int n_checks = 0;
    int prev16   = 0;
    int prev8    = 0;

    always #5 clk = ~clk;

    // Reduction unit: sum of all eight nibbles of the two operands.
    function automatic logic [15:0] nib_sum(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'(a[4*i +: 4]) + int'(b[4*i +: 4]);
        end
        return 16'(s);
    endfunction

    assign red_rd16 = nib_sum(red_rs16, red_rt16);
    assign red_rd8  = nib_sum(red_rs8, red_rt8);

    red_accum_seq #(.LEN_W(8), .ACC_W(16)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready16),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .red_rs   (red_rs16),
        .red_rt   (red_rt16),
        .red_rd   (red_rd16),
        .busy     (busy16),
        .done     (done16),
        .result   (result16)
`ifdef RED_ACC_SAT_EN
        ,
        .sat      (sat16)
`endif
    );

    red_accum_seq #(.LEN_W(8), .ACC_W(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready8),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .red_rs   (red_rs8),
        .red_rt   (red_rt8),
        .red_rd   (red_rd8),
        .busy     (busy8),
        .done     (done8),
        .result   (result8)
`ifdef RED_ACC_SAT_EN
        ,
        .sat      (sat8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: signed add of the low w bits of the reduction value, wrap or clamp.
    task automatic model_step(input logic [15:0] red, input int w, inout int acc, inout bit sat);
        int m, hi, lo, v, s;
        m  = 1 << w;
        hi = (m / 2) - 1;
        lo = -(m / 2);
        v  = int'(red) & (m - 1);
        if (v > hi) v -= m;
        s = acc + v;
        if (s > hi || s < lo) sat = 1'b1;
`ifdef RED_ACC_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        s = ((s % m) + m) % m;
        if (s > hi) s -= m;
`endif
        acc = s;
    endtask

    // Runs one burst from a negedge in idle. gap<0: random in_valid; otherwise gap idle
    // cycles before each pair. poke re-asserts start mid-burst, which must be ignored.
    task automatic run_burst(input int n, input int gap, input bit rnd,
                             input logic [15:0] frs, input logic [15:0] frt, input bit poke);
        int sent, idle, e16, e8;
        bit s16, s8, want;
        logic [15:0] last_rs, last_rt;
        sent = 0; idle = gap; e16 = 0; e8 = 0; s16 = 0; s8 = 0;
        last_rs = red_rs16; last_rt = red_rt16;
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("len0_done", 32'(done16), 32'd1);
            check("len0_result", 32'(result16), 32'd0);
            check("len0_result8", 32'(result8), 32'd0);
            @(negedge clk);
            check("len0_done_clr", 32'(done16), 32'd0);
            check("len0_idle", 32'(busy16), 32'd0);
            prev16 = 0; prev8 = 0;
            return;
        end
        check("busy_run", 32'(busy16), 32'd1);
        while (sent < n) begin
            if (gap < 0) want = ($urandom_range(0, 2) != 0);
            else         want = (idle >= gap);
            in_valid = want;
            in_rs    = rnd ? 16'($urandom) : frs;
            in_rt    = rnd ? 16'($urandom) : frt;
            if (poke && sent == 1) begin
                start = 1'b1;
                len   = 8'd5;
            end
            #1;
            check("in_ready_run", 32'(in_ready16), 32'd1);
            if (want) begin
                model_step(nib_sum(in_rs, in_rt), 16, e16, s16);
                model_step(nib_sum(in_rs, in_rt), 8, e8, s8);
                last_rs = in_rs;
                last_rt = in_rt;
                sent++;
                idle = 0;
            end else begin
                idle++;
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("drain_no_done", 32'(done16), 32'd0);
        check("drain_not_ready", 32'(in_ready16), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done16), 32'd1);
        check("result16", 32'(result16), 32'(e16 & 32'hFFFF));
        check("result8", 32'(result8), 32'(e8 & 32'hFF));
        check("done8_pulse", 32'(done8), 32'd1);
`ifdef RED_ACC_SAT_EN
        check("sat16", 32'(sat16), 32'(s16));
        check("sat8", 32'(sat8), 32'(s8));
`endif
        @(negedge clk);
        check("done_clr", 32'(done16), 32'd0);
        check("idle_busy", 32'(busy16), 32'd0);
        check("result_hold", 32'(result16), 32'(e16 & 32'hFFFF));
        check("red_rs_hold", 32'(red_rs16), 32'(last_rs));
        check("red_rt_hold", 32'(red_rt16), 32'(last_rt));
        prev16 = e16 & 32'hFFFF;
        prev8  = e8 & 32'hFF;
    endtask

    // Starts a len=4 burst, feeds two pairs, then kills it with abort or reset.
    task automatic partial_burst(input bit use_reset);
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_rs    = 16'h2222;
            in_rt    = 16'h3333;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (use_reset) rst_n = 1'b0;
        else           abort = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        if (use_reset) begin
            prev16 = 0;
            prev8  = 0;
            check("rst_red_rs", 32'(red_rs16), 32'd0);
            check("rst_red_rt", 32'(red_rt16), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            check("kill_no_done", 32'(done16 | done8), 32'd0);
            check("kill_idle", 32'(busy16), 32'd0);
            check("kill_not_ready", 32'(in_ready16), 32'd0);
            check("kill_result16", 32'(result16), 32'(prev16));
            check("kill_result8", 32'(result8), 32'(prev8));
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_rs    = '0;
        in_rt    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(busy16), 32'd0);
        check("reset_done", 32'(done16), 32'd0);
        check("reset_ready", 32'(in_ready16), 32'd0);
        check("reset_result", 32'(result16), 32'd0);
        check("reset_red_rs", 32'(red_rs16), 32'd0);
        check("reset_red_rt", 32'(red_rt16), 32'd0);

        run_burst(1, 0, 1'b0, 16'h1111, 16'h1111, 1'b0);
        check("single_pair", 32'(result16), 32'h0008);
        run_burst(3, 0, 1'b0, 16'h1234, 16'h4321, 1'b0);
        check("back_to_back", 32'(result16), 32'h003C);
        run_burst(2, 3, 1'b0, 16'h1111, 16'h1111, 1'b0);
        check("stalls", 32'(result16), 32'h0010);
        run_burst(0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        run_burst(2, 0, 1'b0, 16'h1111, 16'h1111, 1'b1);
        check("start_busy_ignored", 32'(result16), 32'h0010);

        run_burst(3, 0, 1'b0, 16'h1234, 16'h4321, 1'b0);
        partial_burst(1'b0);
        partial_burst(1'b1);

        run_burst(16, 0, 1'b0, 16'h1111, 16'h1111, 1'b0);
`ifdef RED_ACC_SAT_EN
        check("acc8_saturate", 32'(result8), 32'h7F);
`else
        check("acc8_wrap", 32'(result8), 32'h80);
`endif
        check("acc16_16pairs", 32'(result16), 32'h0080);

        for (int k = 0; k < 8; k++) begin
            run_burst(int'($urandom_range(1, 20)), -1, 1'b1, 16'h0000, 16'h0000, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
